// File: rtl/max7219_rx_if.sv
// Write-event bus of the MAX7219 receiver: frame-latched pulse, address/data and framing error.
interface max7219_rx_if;
  logic       wr_valid;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;

  modport master (output wr_valid, output wr_addr, output wr_data, output frame_err);
  modport slave  (input  wr_valid, input  wr_addr, input  wr_data, input  frame_err);
endinterface

// File: rtl/max7219_rx.sv
// MAX7219 3-wire serial receiver: oversamples sck/din/cs and rebuilds the display register file.
// Optional daisy-chain output enabled by defining MAX7219_DOUT_EN.
module max7219_rx #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sck,
  input  logic           din,
  input  logic           cs,
  max7219_rx_if.master   wr,
  output logic [63:0]    digits,
  output logic [7:0]     decode_mode,
  output logic [3:0]     intensity,
  output logic [2:0]     scan_limit,
  output logic           run,
  output logic           disp_test,
  output logic           dout
);

  typedef enum logic [1:0] {StIdle, StShift, StLatch} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync_q, din_sync_q, cs_sync_q;
  logic                   sck_hist_q, cs_hist_q;
  logic                   sck_s, din_s, cs_s;
  logic                   sck_rise, cs_fall, cs_rise;

  logic [15:0] shift_q, shift_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        armed_q, armed_d;

  logic        wr_valid_q, frame_err_q;
  logic [3:0]  wr_addr_q;
  logic [7:0]  wr_data_q;
  logic [63:0] digits_q;
  logic [7:0]  decode_mode_q;
  logic [3:0]  intensity_q;
  logic [2:0]  scan_limit_q;
  logic        run_q, disp_test_q;
  logic [3:0]  addr_m1;

  // Sync flops reset to 0 so a cs already low at reset release never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q <= '0;
      din_sync_q <= '0;
      cs_sync_q  <= '0;
      sck_hist_q <= 1'b0;
      cs_hist_q  <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], din};
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      sck_hist_q <= sck_s;
      cs_hist_q  <= cs_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign din_s    = din_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_hist_q;
  assign cs_fall  = ~cs_s & cs_hist_q;
  assign cs_rise  = cs_s & ~cs_hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          shift_d = '0;
          cnt_d   = '0;
          armed_d = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        // A cs rise in the same cycle as an sck rise ends the frame without counting that edge.
        if (cs_rise && armed_q) begin
          state_d = StLatch;
        end else if (sck_rise) begin
          shift_d = {shift_q[14:0], din_s};
          if (cnt_q != 5'd16) cnt_d = cnt_q + 5'd1;
        end
      end
      StLatch: begin
        armed_d = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign addr_m1 = shift_q[11:8] - 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      digits_q      <= '0;
      decode_mode_q <= '0;
      intensity_q   <= '0;
      scan_limit_q  <= '0;
      run_q         <= 1'b0;
      disp_test_q   <= 1'b0;
    end else begin
      wr_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (state_q == StLatch) begin
        if (cnt_q == 5'd16) begin
          wr_valid_q <= 1'b1;
          wr_addr_q  <= shift_q[11:8];
          wr_data_q  <= shift_q[7:0];
          case (shift_q[11:8])
            4'h1, 4'h2, 4'h3, 4'h4,
            4'h5, 4'h6, 4'h7, 4'h8: digits_q[{addr_m1[2:0], 3'b000} +: 8] <= shift_q[7:0];
            4'h9:    decode_mode_q <= shift_q[7:0];
            4'hA:    intensity_q   <= shift_q[3:0];
            4'hB:    scan_limit_q  <= shift_q[2:0];
            4'hC:    run_q         <= shift_q[0];
            4'hF:    disp_test_q   <= shift_q[0];
            default: ;
          endcase
        end else begin
          frame_err_q <= 1'b1;
        end
      end
    end
  end

`ifdef MAX7219_DOUT_EN
  logic dout_q;
  logic sck_fall;

  assign sck_fall = ~sck_s & sck_hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= 1'b0;
    end else if (sck_fall && !cs_s) begin
      dout_q <= shift_q[15];
    end
  end

  assign dout = dout_q;
`else
  assign dout = 1'b0;
`endif

  assign wr.wr_valid  = wr_valid_q;
  assign wr.wr_addr   = wr_addr_q;
  assign wr.wr_data   = wr_data_q;
  assign wr.frame_err = frame_err_q;
  assign digits       = digits_q;
  assign decode_mode  = decode_mode_q;
  assign intensity    = intensity_q;
  assign scan_limit   = scan_limit_q;
  assign run          = run_q;
  assign disp_test    = disp_test_q;

endmodule

// File: tb/tb_max7219_rx.sv
// Self-checking bench for max7219_rx: directed and random frames against a register-file model.
module tb_max7219_rx;
  localparam int unsigned SyncStages = 2;
  localparam int unsigned Half       = 4;  // sck half period in clk cycles

  logic        clk = 1'b0;
  logic        rst, sck, din, cs;
  logic [63:0] digits;
  logic [7:0]  decode_mode;
  logic [3:0]  intensity;
  logic [2:0]  scan_limit;
  logic        run, disp_test, dout;

  max7219_rx_if bus ();

  max7219_rx #(.SYNC_STAGES(SyncStages)) dut (
    .clk         (clk),
    .rst         (rst),
    .sck         (sck),
    .din         (din),
    .cs          (cs),
    .wr          (bus.master),
    .digits      (digits),
    .decode_mode (decode_mode),
    .intensity   (intensity),
    .scan_limit  (scan_limit),
    .run         (run),
    .disp_test   (disp_test),
    .dout        (dout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference register file.
  logic [7:0] m_digit [8];
  logic [7:0] m_decode;
  logic [3:0] m_inten;
  logic [2:0] m_scan;
  logic       m_run, m_test;
  logic [3:0] m_addr;
  logic [7:0] m_data;

  // Monitor state.
  int          cyc = 0;
  int          n_valid = 0;
  int          n_err = 0;
  int          valid_cyc = 0;
  logic [80:0] snap;
  logic [31:0] dout_bits;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.wr_valid) begin
      n_valid   = n_valid + 1;
      valid_cyc = cyc;
      snap      = {digits, decode_mode, intensity, scan_limit, run, disp_test};
    end
    if (bus.frame_err) n_err = n_err + 1;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [80:0] model_vec();
    logic [63:0] d;
    for (int i = 0; i < 8; i++) d[i*8 +: 8] = m_digit[i];
    return {d, m_decode, m_inten, m_scan, m_run, m_test};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_digit[i] = 8'h00;
    m_decode = '0; m_inten = '0; m_scan = '0; m_run = 1'b0; m_test = 1'b0;
    m_addr = '0; m_data = '0;
  endfunction

  // A frame is the last 16 bits clocked in; only full frames write.
  function automatic void model_frame(input logic [31:0] value, input int n);
    logic [15:0] w;
    int a;
    if (n < 16) return;
    w = value[15:0];
    a = int'(w[11:8]);
    m_addr = w[11:8];
    m_data = w[7:0];
    if (a >= 1 && a <= 8) m_digit[a-1] = m_data;
    else if (a == 9)  m_decode = m_data;
    else if (a == 10) m_inten  = m_data[3:0];
    else if (a == 11) m_scan   = m_data[2:0];
    else if (a == 12) m_run    = m_data[0];
    else if (a == 15) m_test   = m_data[0];
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends n bits MSB first; abort_bit >= 0 pulses rst right after that many sck rises.
  task automatic send_frame(input logic [31:0] value, input int n, input int abort_bit,
                            output int rise_cyc);
    cs = 1'b0;
    wait_clk(Half);
    for (int i = 0; i < n; i++) begin
      din = value[n-1-i];
      dout_bits[31-i] = dout;
      wait_clk(Half);
      sck = 1'b1;
      wait_clk(Half);
      sck = 1'b0;
      if (abort_bit == i + 1) begin
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
      end
    end
    wait_clk(Half);
    rise_cyc = cyc;
    cs = 1'b1;
    wait_clk(3 * Half);
  endtask

  task automatic frame_and_check(input string tag, input logic [31:0] value, input int n);
    int v0, e0, rc;
    v0 = n_valid;
    e0 = n_err;
    send_frame(value, n, -1, rc);
    model_frame(value, n);
    check({tag, " valid_cnt"}, 128'(n_valid - v0), (n >= 16) ? 128'd1 : 128'd0);
    check({tag, " err_cnt"}, 128'(n_err - e0), (n < 16) ? 128'd1 : 128'd0);
    check({tag, " addr"}, 128'(bus.wr_addr), 128'(m_addr));
    check({tag, " data"}, 128'(bus.wr_data), 128'(m_data));
    check({tag, " regs"}, 128'({digits, decode_mode, intensity, scan_limit, run, disp_test}),
          128'(model_vec()));
    if (n >= 16) begin
      check({tag, " latency"}, 128'(valid_cyc - rc), 128'(SyncStages + 2));
      check({tag, " regs_at_valid"}, 128'(snap), 128'(model_vec()));
    end
  endtask

  initial begin
    int rc, v0, e0, n;
    logic [31:0] val;
    rst = 1'b1; sck = 1'b0; din = 1'b0; cs = 1'b1;
    dout_bits = '0;
    model_reset();
    wait_clk(4);
    rst = 1'b0;
    wait_clk(Half);

    check("reset regs", 128'({digits, decode_mode, intensity, scan_limit, run, disp_test}), 128'd0);
    check("reset bus", 128'({bus.wr_valid, bus.frame_err, bus.wr_addr, bus.wr_data, dout}), 128'd0);

    frame_and_check("digit1", 32'h0230, 16);
    frame_and_check("inten", 32'h0A05, 16);
    frame_and_check("scan", 32'h0B07, 16);
    frame_and_check("run", 32'h0C01, 16);
    frame_and_check("test", 32'h0F01, 16);
    frame_and_check("short", 32'h0A3, 12);
    frame_and_check("long", 32'hFF0901, 24);
    frame_and_check("digit7", 32'h0855, 16);

    // Reset during the 8th bit discards the frame and clears everything.
    v0 = n_valid;
    e0 = n_err;
    send_frame(32'h0C01, 16, 8, rc);
    model_reset();
    check("abort valid_cnt", 128'(n_valid - v0), 128'd0);
    check("abort err_cnt", 128'(n_err - e0), 128'd0);
    check("abort regs", 128'({digits, decode_mode, intensity, scan_limit, run, disp_test}),
          128'd0);
    frame_and_check("noop", 32'h0000, 16);

`ifdef MAX7219_DOUT_EN
    send_frame(32'h0112_0234, 32, -1, rc);
    model_frame(32'h0112_0234, 32);
    check("dout stream", 128'(dout_bits[15:0]), 128'h0112);
    check("dout latch", 128'({bus.wr_addr, bus.wr_data}), 128'h234);
`endif

    for (int k = 0; k < 30; k++) begin
      n   = int'($urandom_range(10, 24));
      val = $urandom;
      if (n < 32) val = val & ((32'd1 << n) - 32'd1);
      frame_and_check($sformatf("rand%0d", k), val, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
